// File: rtl/equal_seq_ctrl.sv
// rtl/equal_seq_ctrl.sv - slice-serial equality checker with start/busy/done handshake and early exit
module equal_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 2,
  localparam int N  = WIDTH / SLICE,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             equal_out,
  output logic [CW-1:0]    slices_out
);

  // Operand width must split into whole slices.
  if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_param
    $error("equal_seq_ctrl: WIDTH must be a non-zero multiple of SLICE");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  // Operands are held as shift registers: the slice under test is always
  // the low SLICE bits, so slice i of the latched word sits there after i shifts.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;

  logic             slice_match;
  logic             last_slice;
  logic             accept;
  logic             finish;

  assign slice_match = ~|(a_q[SLICE-1:0] ^ b_q[SLICE-1:0]);
  assign last_slice  = (idx == IW'(N - 1));

  // A start is only honoured outside COMPARE; DONE -> COMPARE is back-to-back.
  assign accept = start_in && (state != S_COMPARE);

  // Compare ends on the first mismatching slice or after the last slice matches.
  assign finish = (state == S_COMPARE) && (!slice_match || last_slice);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    state_next = start_in ? S_COMPARE : S_IDLE;
      S_COMPARE: state_next = finish ? S_DONE : S_COMPARE;
      S_DONE:    state_next = start_in ? S_COMPARE : S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decode the state register only, so no input reaches them.
  always_comb begin
    busy_out = 1'b0;
    done_out = 1'b0;
    unique case (state)
      S_COMPARE: busy_out = 1'b1;
      S_DONE:    done_out = 1'b1;
      default: begin
        busy_out = 1'b0;
        done_out = 1'b0;
      end
    endcase
  end

  // Operand capture, slice stepping and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      idx        <= '0;
      equal_out  <= 1'b0;
      slices_out <= '0;
    end else if (accept) begin
      a_q <= a_in;
      b_q <= b_in;
      idx <= '0;
    end else if (state == S_COMPARE) begin
      if (finish) begin
        // slice_match here is 1 only when the final slice matched too.
        equal_out  <= slice_match;
        slices_out <= CW'(idx) + CW'(1);
      end else begin
        a_q <= a_q >> SLICE;
        b_q <= b_q >> SLICE;
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_equal_seq_ctrl.sv
// tb/tb_equal_seq_ctrl.sv - self-checking bench for equal_seq_ctrl against a latency/result model
module tb_equal_seq_ctrl;

  localparam int WIDTH = 16;
  localparam int SLICE = 2;
  localparam int N     = WIDTH / SLICE;
  localparam int CW    = $clog2(N) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy_out;
  logic             done_out;
  logic             equal_out;
  logic [CW-1:0]    slices_out;

  int n_cmp = 0;
  int n_bad = 0;

  equal_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_in   (start_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .equal_out  (equal_out),
    .slices_out (slices_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  // Result of comparing two words: equal flag and slices examined.
  function automatic void ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     output logic eq, output int sl);
    logic [WIDTH-1:0] diff;
    diff = a ^ b;
    eq   = 1'b1;
    sl   = N;
    for (int i = 0; i < N; i++) begin
      if (((diff >> (i * SLICE)) & ((1 << SLICE) - 1)) != 0) begin
        eq = 1'b0;
        sl = i + 1;
        return;
      end
    end
  endfunction

  // Model: an accepted start keeps the block busy for as many cycles as slices
  // are examined, then a single done cycle publishes the result.
  logic m_valid = 1'b0;
  logic e_busy, e_done, e_eq;
  int   e_sl, rem;
  logic p_eq;
  int   p_sl;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      e_busy  = 1'b0;
      e_done  = 1'b0;
      e_eq    = 1'b0;
      e_sl    = 0;
      rem     = 0;
    end else if (m_valid) begin
      if (e_busy) begin
        rem--;
        if (rem == 0) begin
          e_busy = 1'b0;
          e_done = 1'b1;
          e_eq   = p_eq;
          e_sl   = p_sl;
        end
      end else begin
        e_done = 1'b0;
        if (start_in) begin
          ref_result(a_in, b_in, p_eq, p_sl);
          rem    = p_sl;
          e_busy = 1'b1;
        end
      end
    end
  end

  // Every cycle, away from the active edge, outputs must agree with the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_busy", busy_out, e_busy);
      check("model_done", done_out, e_done);
      check("model_equal", equal_out, e_eq);
      check("model_slices", slices_out, e_sl);
    end
  end

  // One start pulse; checks the done cycle number and result against literals.
  task automatic run_literal(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input int exp_lat, input logic exp_eq, input int exp_sl);
    int c;
    @(posedge clk); #1;
    a_in = a; b_in = b; start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    a_in = ~a;
    c = 1;
    forever begin
      @(negedge clk);
      if (c == 1) check({nm, "_busy1"}, busy_out, 1'b1);
      if (done_out || c == 20) break;
      @(posedge clk);
      c++;
    end
    check({nm, "_lat"}, done_out ? c : -1, exp_lat);
    check({nm, "_eq"}, equal_out, exp_eq);
    check({nm, "_sl"}, slices_out, exp_sl);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, cyc_sum, k;
    reset = 1'b1; start_in = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_eq", equal_out, 0);
    check("rst_sl", slices_out, 0);

    run_literal("t1_equal", 16'hA5C3, 16'hA5C3, 9, 1'b1, 8);
    run_literal("t2_slice0", 16'h0001, 16'h0000, 2, 1'b0, 1);
    run_literal("t3_slice7", 16'h8000, 16'h0000, 9, 1'b0, 8);
    run_literal("tx_slice2", 16'h0030, 16'h0000, 4, 1'b0, 3);

    // Start held high with equal operands: done every 9 cycles, mid-compare operand changes ignored.
    @(posedge clk); #1;
    a_in = 16'h1234; b_in = 16'h1234; start_in = 1'b1;
    @(posedge clk);
    pulses = 0; cyc_sum = 0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (done_out) begin
        pulses++;
        cyc_sum += c;
      end
      if (c == 3) begin a_in = 16'hFFFF; b_in = 16'h0000; end
      if (c == 9) begin a_in = 16'h1234; b_in = 16'h1234; end
      @(posedge clk);
    end
    check("t4_pulses", pulses, 4);
    check("t4_cycles", cyc_sum, 90);
    check("t4_eq", equal_out, 1);
    // Continue streaming with alternating equal/unequal operands each cycle.
    for (int c = 0; c < 60; c++) begin
      #1;
      a_in = WIDTH'($urandom);
      b_in = (c % 2 == 0) ? a_in : (a_in ^ WIDTH'(1 << (c % WIDTH)));
      @(posedge clk);
    end
    #1 start_in = 1'b0;
    repeat (12) @(posedge clk);

    // Reset in cycle 4 of an equal compare, with start also high.
    #1 a_in = 16'h5A5A; b_in = 16'h5A5A; start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1; start_in = 1'b1;
    @(posedge clk); #1 reset = 1'b0; start_in = 1'b0;
    @(negedge clk);
    check("t5_busy", busy_out, 0);
    check("t5_done", done_out, 0);
    check("t5_eq", equal_out, 0);
    check("t5_sl", slices_out, 0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_out) pulses++;
    end
    check("t5_no_done", pulses, 0);

    // Random pairs, each issued in the done cycle of the previous one.
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      a_in = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0, 1: b_in = a_in;
        2:    b_in = a_in ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: b_in = WIDTH'($urandom);
      endcase
      start_in = 1'b1;
      @(posedge clk); #1 start_in = 1'b0;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!done_out && k < 12);
      if (!done_out) check("t6_timeout", 0, 1);
    end
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
